div_subshift: RTL

- Iterative shift-subtract (restoring) integer divider; the inverse counterpart of the team's shift-add multiplier.
- Computes quotient and remainder of op_a / op_b, signed or unsigned, one quotient bit per clock.
- Uses the same level-sensitive en/done protocol as the multiplier, so either unit can sit behind the same ALU/CPU sequencer.

---
 rtl/div_pkg.sv | 35 +++
 rtl/div_step.sv | 31 +++
 rtl/div_subshift.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the shift-subtract divider: counter sizing,
// counter landmarks, phase names and the operand magnitude helper.
package div_pkg;

  localparam int DIV_MAX_W = 128;
  localparam int PC_LOAD   = 0;

  typedef enum logic [1:0] {
    PH_LOAD,
    PH_ITER,
    PH_FINISH,
    PH_HOLD
  } phase_e;

  function automatic int div_pc_w(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

  function automatic int pc_hold(input int data_w);
    return data_w;
  endfunction

  // Magnitude of a data_w-bit value; the most-negative input maps to 2^(data_w-1).
  function automatic logic [DIV_MAX_W-1:0] abs_val(input logic [DIV_MAX_W-1:0] x,
                                                   input logic                 sign,
                                                   input int                   data_w);
    logic [DIV_MAX_W-1:0] mask;
    mask = (DIV_MAX_W'(1) << data_w) - DIV_MAX_W'(1);
    if (sign && x[data_w-1]) begin
      return (~x + DIV_MAX_W'(1)) & mask;
    end
    return x & mask;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract the divisor
// from R and keep the difference only when it did not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W:0]   rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W+1:0] remShift;
  logic [DATA_W+1:0] trial;

  // Shift in the next dividend bit and decide this quotient bit from the trial sign.
  always_comb begin
    remShift = {rem_i, quo_i[DATA_W-1]};
    trial    = remShift - {2'b00, divisor_i};
    if (!trial[DATA_W+1]) begin
      rem_o = trial[DATA_W:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o = remShift[DATA_W:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_subshift.sv
// Iterative signed/unsigned restoring divider producing one quotient bit per
// clock, driven by a level-sensitive en and answering with a one-cycle done.
module div_subshift
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sign,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int              PC_W      = div_pc_w(DATA_W);
  localparam logic [PC_W-1:0] PC_LOAD_V = PC_W'(PC_LOAD);
  localparam logic [PC_W-1:0] PC_LAST   = PC_W'(DATA_W - 1);
  localparam logic [PC_W-1:0] PC_HOLD_V = PC_W'(pc_hold(DATA_W));

  logic [PC_W-1:0]     pc_q, pc_d;
  logic [2*DATA_W:0]   work_q, work_d;
  logic [DATA_W-1:0]   absB_q, absB_d;
  logic [DATA_W-1:0]   opA_q, opA_d;
  logic                qNeg_q, qNeg_d;
  logic                rNeg_q, rNeg_d;
  logic                div0_q, div0_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   quot_q, quot_d;
  logic [DATA_W-1:0]   rem_q, rem_d;

  phase_e              phase;
  logic [DATA_W-1:0]   absA, absB;
  logic [DATA_W:0]     stepRemIn, stepRemOut;
  logic [DATA_W-1:0]   stepQuoIn, stepQuoOut, stepDiv;

  assign absA = DATA_W'(abs_val(DIV_MAX_W'(op_a), sign, DATA_W));
  assign absB = DATA_W'(abs_val(DIV_MAX_W'(op_b), sign, DATA_W));

  // Name the current phase from the iteration counter.
  always_comb begin
    phase = PH_HOLD;
    if (pc_q == PC_LOAD_V) begin
      phase = PH_LOAD;
    end else if (pc_q < PC_LAST) begin
      phase = PH_ITER;
    end else if (pc_q == PC_LAST) begin
      phase = PH_FINISH;
    end
  end

  // During LOAD the step works on fresh operand magnitudes instead of the working register.
  always_comb begin
    stepRemIn = work_q[2*DATA_W:DATA_W];
    stepQuoIn = work_q[DATA_W-1:0];
    stepDiv   = absB_q;
    if (phase == PH_LOAD) begin
      stepRemIn = '0;
      stepQuoIn = absA;
      stepDiv   = absB;
    end
  end

  div_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .rem_i    (stepRemIn),
    .quo_i    (stepQuoIn),
    .divisor_i(stepDiv),
    .rem_o    (stepRemOut),
    .quo_o    (stepQuoOut)
  );

  // State register: every register clears immediately when rst_n drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      work_q <= '0;
      absB_q <= '0;
      opA_q  <= '0;
      qNeg_q <= 1'b0;
      rNeg_q <= 1'b0;
      div0_q <= 1'b0;
      done_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      work_q <= work_d;
      absB_q <= absB_d;
      opA_q  <= opA_d;
      qNeg_q <= qNeg_d;
      rNeg_q <= rNeg_d;
      div0_q <= div0_d;
      done_q <= done_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
    end
  end

  // Counter advance: en low aborts to LOAD, FINISH parks in HOLD until en drops.
  always_comb begin
    pc_d = pc_q;
    if (!en) begin
      pc_d = PC_LOAD_V;
    end else begin
      case (phase)
        PH_LOAD, PH_ITER: pc_d = pc_q + PC_W'(1);
        PH_FINISH:        pc_d = PC_HOLD_V;
        default:          pc_d = pc_q;
      endcase
    end
  end

  // Datapath and results: capture operands on LOAD, iterate, then sign-fix on FINISH.
  always_comb begin
    work_d = work_q;
    absB_d = absB_q;
    opA_d  = opA_q;
    qNeg_d = qNeg_q;
    rNeg_d = rNeg_q;
    div0_d = div0_q;
    done_d = 1'b0;
    quot_d = quot_q;
    rem_d  = rem_q;
    if (!en) begin
      work_d = '0;
    end else begin
      case (phase)
        PH_LOAD: begin
          work_d = {stepRemOut, stepQuoOut};
          absB_d = absB;
          opA_d  = op_a;
          qNeg_d = sign & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
          rNeg_d = sign & op_a[DATA_W-1];
          div0_d = (op_b == '0);
        end
        PH_ITER: begin
          work_d = {stepRemOut, stepQuoOut};
        end
        PH_FINISH: begin
          work_d = {stepRemOut, stepQuoOut};
          done_d = 1'b1;
          if (div0_q) begin
            quot_d = '1;
            rem_d  = opA_q;
          end else begin
            quot_d = qNeg_q ? -stepQuoOut : stepQuoOut;
            rem_d  = rNeg_q ? -stepRemOut[DATA_W-1:0] : stepRemOut[DATA_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule
